// File: rtl/rotate_pkg.sv
// rotate_pkg: shared FSM state codes, direction encodings and step limit for the rotate sequencer.
package rotate_pkg;
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t ROT  = 2'd1;
   localparam state_t DONE = 2'd2;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   function automatic int max_step(input int width);
      return width - 1;
   endfunction
endpackage

// File: rtl/rotate_sequencer_if.sv
// rotate_sequencer_if: command/result handshake bundle between a requester and the rotate sequencer.
interface rotate_sequencer_if #(parameter int WIDTH = 4, parameter int CNT_W = 4);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic [CNT_W-1:0] cnt;
   logic             dir;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
   logic             busy;
   modport master (output in_valid, din, cnt, dir, out_ready, input in_ready, out_valid, dout, busy);
   modport slave  (input in_valid, din, cnt, dir, out_ready, output in_ready, out_valid, dout, busy);
endinterface

// File: rtl/rotate_sequencer_rot_step.sv
// rot_step: combinational single-step rotate of a word by a bounded amount, left or right.
module rot_step
   import rotate_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SW    = 2
) (
   input  logic [WIDTH-1:0] word,
   input  logic [SW-1:0]    step,
   input  logic             dir,
   output logic [WIDTH-1:0] rotated
);
   // step never reaches WIDTH, so a zero step makes the wrap term shift out completely
   assign rotated = (dir == DIR_RIGHT) ? ((word >> step) | (word << (WIDTH - step)))
                                       : ((word << step) | (word >> (WIDTH - step)));
endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle rotator taking at most WIDTH-1 positions per cycle.
// Define ROTATE_SEQUENCER_MOD_REDUCE_EN to reduce the count mod WIDTH at acceptance (single ROT cycle).
module rotate_sequencer
   import rotate_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input logic               clk,
   input logic               rst,
   rotate_sequencer_if.slave bus
);
   localparam int SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(max_step(WIDTH));
   state_t           state;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] rotated;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] load;
   logic             dir_q;
   logic             last;
   logic [SW-1:0]    step;
   assign last = remaining <= MAX_C;
   assign step = last ? SW'(remaining) : SW'(MAX_C);
`ifdef ROTATE_SEQUENCER_MOD_REDUCE_EN
   assign load = CNT_W'(bus.cnt % WIDTH);
`else
   assign load = bus.cnt;
`endif
   rot_step #(.WIDTH(WIDTH), .SW(SW)) u_step (
      .word    (word),
      .step    (step),
      .dir     (dir_q),
      .rotated (rotated)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         word      <= '0;
         remaining <= '0;
         dir_q     <= DIR_LEFT;
      end else if (state == IDLE) begin
         if (bus.in_valid) begin
            word      <= bus.din;
            remaining <= load;
            dir_q     <= bus.dir;
            state     <= ROT;
         end
      end else if (state == ROT) begin
         word      <= rotated;
         remaining <= remaining - CNT_W'(step);
         state     <= last ? DONE : ROT;
      end else begin
         state <= bus.out_ready ? IDLE : DONE;
      end
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.dout      = word;
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: table-driven directed checks plus multi-cycle corner sequences.
module tb_rotate_sequencer;
`ifdef ROTATE_SEQUENCER_MOD_REDUCE_EN
   localparam bit MOD = 1'b1;
`else
   localparam bit MOD = 1'b0;
`endif
   typedef struct {
      logic [3:0] din;
      logic [3:0] cnt;
      logic       dir;
      logic [3:0] dout;
      int         cycles;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs [10];
   rotate_sequencer_if #(.WIDTH(4), .CNT_W(4)) bus ();
   rotate_sequencer #(.WIDTH(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask
   task automatic run_cmd(input string name, input logic [3:0] d, input logic [3:0] c,
                          input logic dr, input logic [3:0] exp_dout, input int exp_cyc);
      int n;
      bus.din = d; bus.cnt = c; bus.dir = dr; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.din = ~d; bus.cnt = ~c; bus.dir = ~dr;
      check({name, " busy"}, bus.busy, 1);
      wait_done(n);
      check({name, " rot_cycles"}, n, MOD ? 1 : exp_cyc);
      check({name, " dout"}, bus.dout, exp_dout);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({name, " in_ready_after"}, bus.in_ready, 1);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
   initial begin
      int n;
      vecs[0] = '{4'b1011, 4'd1,  1'b0, 4'b0111, 1};
      vecs[1] = '{4'b1011, 4'd1,  1'b1, 4'b1101, 1};
      vecs[2] = '{4'b1011, 4'd7,  1'b0, 4'b1101, 3};
      vecs[3] = '{4'b1011, 4'd0,  1'b0, 4'b1011, 1};
      vecs[4] = '{4'b1011, 4'd12, 1'b0, 4'b1011, 4};
      vecs[5] = '{4'b0001, 4'd5,  1'b1, 4'b1000, 2};
      vecs[6] = '{4'b1100, 4'd15, 1'b1, 4'b1001, 5};
      vecs[7] = '{4'b0110, 4'd4,  1'b0, 4'b0110, 2};
      vecs[8] = '{4'b1011, 4'd7,  1'b1, 4'b0111, 3};
      vecs[9] = '{4'b1000, 4'd3,  1'b0, 4'b0100, 1};
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.din = '0; bus.cnt = '0; bus.dir = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset in_ready", bus.in_ready, 1);
      check("reset out_valid", bus.out_valid, 0);
      check("reset busy", bus.busy, 0);
      check("reset dout", bus.dout, 0);
      #5 rst = 1'b0;
      for (int i = 0; i < 10; i++)
         run_cmd($sformatf("vec%0d", i), vecs[i].din, vecs[i].cnt, vecs[i].dir, vecs[i].dout, vecs[i].cycles);
      // result held while the consumer stalls; new commands must be ignored
      bus.din = 4'b1011; bus.cnt = 4'd1; bus.dir = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_done(n);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = i[0]; bus.din = 4'(i); bus.cnt = 4'd2;
         @(posedge clk); #1;
         check($sformatf("stall%0d out_valid", i), bus.out_valid, 1);
         check($sformatf("stall%0d dout", i), bus.dout, 4'b0111);
         check($sformatf("stall%0d in_ready", i), bus.in_ready, 0);
      end
      bus.din = 4'b0001; bus.cnt = 4'd1; bus.dir = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("release no_same_cycle_accept", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("accept after idle busy", bus.busy, 1);
      wait_done(n);
      check("accept after idle dout", bus.dout, 4'b1000);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      // asynchronous reset in the middle of a rotation
      bus.din = 4'b1011; bus.cnt = 4'd12; bus.dir = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("midrot rst in_ready", bus.in_ready, 1);
      check("midrot rst out_valid", bus.out_valid, 0);
      check("midrot rst busy", bus.busy, 0);
      check("midrot rst dout", bus.dout, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrot no_result", bus.out_valid, 0);
      run_cmd("after_rst", 4'b0001, 4'd1, 1'b1, 4'b1000, 1);
      // reset while a result is waiting in DONE
      bus.din = 4'b0110; bus.cnt = 4'd1; bus.dir = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_done(n);
      check("done reached", bus.out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("done rst out_valid", bus.out_valid, 0);
      check("done rst dout", bus.dout, 0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("done rst idle", bus.in_ready, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
